nibbler_fetch: RTL and testbench
================================

// Module: nibbler_fetch
// PURPOSE
//   Instruction fetch stage of the Nibbler CPU; sits directly upstream of the program Rom.
//   Holds the 12-bit PC, drives rom_addr, captures rom_data (combinational Rom, 8-bit words).
//   Assembles 1-byte (short) or 2-byte (long, 12-bit target) instructions and hands them to
//   the decoder with a valid/ready handshake.
//   Redirects the PC on taken jumps.
// PARAMETERS
//   ADDR_W    12        PC / Rom address width
//   DATA_W    8         Rom word width; opcode = [7:4], operand = [3:0]
//   RESET_PC  12'h000   PC value loaded at reset
//   LONG_OPS  16'hFF00  bit n set => opcode n is two-byte (jumps, ld/st); default: opcode[3]=1
// PORTS
//   clk          in   1       single clock, rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   rom_addr     out  ADDR_W  Rom address, always equal to the PC register
//   rom_data     in   DATA_W  Rom word at rom_addr; valid in the same cycle
//   instr_valid  out  1       assembled instruction available
//   instr_ready  in   1       decoder accepts the instruction this cycle
//   take_jump    in   1       sampled only with valid&&ready on a long instruction: load target
//   opcode       out  4       first byte [7:4]
//   operand      out  4       first byte [3:0]
//   target       out  ADDR_W  {operand, second byte} for long ops, else 0
//   is_long      out  1       current instruction is two-byte
//   instr_pc     out  ADDR_W  address of the first byte of the current instruction
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert):
//     - pc = RESET_PC; state = F0
//     - instr_valid, opcode, operand, target, is_long = 0; instr_pc = RESET_PC
//   FSM, states F0 (first byte), F1 (second byte), HOLD (present instruction):
//     - F0:   opcode/operand <= rom_data; instr_pc <= pc; pc <= pc+1; target <= 0
//             -> F1 if LONG_OPS[rom_data[7:4]], else HOLD
//     - F1:   target <= {operand, rom_data}; pc <= pc+1 -> HOLD
//     - HOLD: instr_valid = 1; outputs stable until accepted
//             - ready low: stay HOLD, PC unchanged.
//             - valid&&ready: -> F0; if take_jump && is_long, pc <= target, else pc unchanged.
//             - take_jump on a short op is ignored.
//   instr_valid is registered; it is 1 only in HOLD.
//   Latency from entering F0: short instr valid on cycle 2, long on cycle 3.
//   Minimum throughput: 1 short instr per 2 cycles, 1 long per 3.
//   PC arithmetic is modulo 2^ADDR_W:
//     - 12'hFFF+1 = 12'h000
//     - a long op at 12'hFFF takes its second byte from 12'h000
//   Jump to the current instr_pc is legal: next fetch re-reads that address.
//   reset_n low mid-F1 or mid-HOLD discards the partial/pending instruction; restart at RESET_PC.
// STRUCTURE
//   nibbler_pkg:
//     - ADDR_W/DATA_W localparams
//     - opcode_t (logic [3:0])
//     - fetch_state_t enum {F0, F1, HOLD}
//     - function is_long_op(opcode_t, LONG_OPS)
//   Sub-module nibbler_pc: PC register with inc/load, async active-low reset to RESET_PC.
//   Top: FSM + instruction registers; Rom instantiated outside, in the CPU top.
// TESTING (bench instantiates nibbler_fetch + Rom)
//   1. reset_n=0 then 1, Rom[0]=8'h12, ready=1
//      -> rom_addr 000,001; HOLD on cycle 2: opcode=1, operand=2, is_long=0
//   2. Rom[0]=8'hC3, Rom[1]=8'h45, take_jump=1
//      -> target=12'h345, is_long=1, valid on cycle 3; next rom_addr=12'h345
//   3. Same long op with take_jump=0
//      -> next rom_addr=12'h002; take_jump=1 on a short op leaves PC unchanged
//   4. Hold ready=0 for 5 cycles in HOLD
//      -> valid stays 1, opcode/target/rom_addr stable; accepted exactly once
//   5. RESET_PC=12'hFFF, Rom[FFF]=8'h9A, Rom[000]=8'hBC
//      -> target=12'hABC, instr_pc=FFF, pc wraps to 001
//   6. Assert reset_n=0 in F1
//      -> instr_valid=0 immediately, rom_addr=RESET_PC; no stale instruction after release

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types and helpers for the Nibbler fetch stage.
package nibbler_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef logic [3:0] opcode_t;

  // F0: capture first byte, F1: capture second byte, HOLD: present to decoder
  typedef enum logic [1:0] {
    F0   = 2'd0,
    F1   = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // An opcode is two-byte when its bit is set in the long-op mask.
  function automatic logic is_long_op(opcode_t op, logic [15:0] long_ops);
    return long_ops[op];
  endfunction

endpackage

// File: rtl/nibbler_pc.sv
// Program counter with increment and load; load wins over increment.
module nibbler_pc
  import nibbler_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // next PC: jump target, sequential increment (wraps modulo 2^ADDR_W) or hold
  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_q + ADDR_W'(1);
  end

  // PC register, restarts at RESET_PC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/nibbler_fetch.sv
// Nibbler instruction fetch: walks the PC over a combinational Rom, assembles
// short (1-byte) and long (2-byte) instructions and presents them to the decoder.
//
// Handshake: instr_valid is high only in HOLD and all instruction outputs stay
// stable while it is high; the instruction is consumed on a cycle where
// instr_valid && instr_ready, and take_jump is looked at only on that cycle and
// only for long instructions.
module nibbler_fetch
  import nibbler_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [15:0]       LONG_OPS = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              take_jump,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic [ADDR_W-1:0] target,
  output logic              is_long,
  output logic [ADDR_W-1:0] instr_pc,
  output fetch_state_t      state_dbg
);

  fetch_state_t      state_q, state_d;
  opcode_t           opcode_q, opcode_d;
  logic [3:0]        operand_q, operand_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              is_long_q, is_long_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              pc_inc, pc_load;
  logic [ADDR_W-1:0] pc;

  nibbler_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (target_q),
    .pc       (pc)
  );

  // next state, next instruction registers and PC control
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    target_d   = target_q;
    is_long_d  = is_long_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state_q)
      F0: begin
        opcode_d   = rom_data[7:4];
        operand_d  = rom_data[3:0];
        instr_pc_d = pc;
        target_d   = '0;
        pc_inc     = 1'b1;
        is_long_d  = is_long_op(rom_data[7:4], LONG_OPS);
        if (is_long_op(rom_data[7:4], LONG_OPS)) begin
          state_d = F1;
        end else begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      F1: begin
        target_d = {operand_q, rom_data};
        pc_inc   = 1'b1;
        state_d  = HOLD;
        valid_d  = 1'b1;
      end
      HOLD: begin
        if (instr_ready) begin
          state_d = F0;
          valid_d = 1'b0;
          pc_load = take_jump && is_long_q;
        end
      end
      default: begin
        state_d = F0;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered instruction outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= F0;
      opcode_q   <= '0;
      operand_q  <= '0;
      target_q   <= '0;
      is_long_q  <= 1'b0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      target_q   <= target_d;
      is_long_q  <= is_long_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_addr    = pc;
  assign instr_valid = valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign target      = target_q;
  assign is_long     = is_long_q;
  assign instr_pc    = instr_pc_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_nibbler_fetch.sv
// Bench for nibbler_fetch: two instances (RESET_PC 000 and FFF) each with a Rom array.
module tb_nibbler_fetch;
  import nibbler_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n0, reset_n1;
  logic [11:0] rom_addr0, rom_addr1, target0, target1, instr_pc0, instr_pc1;
  logic [7:0]  rom_data0, rom_data1;
  logic        valid0, valid1, ready0, ready1, tj0, tj1, long0, long1;
  logic [3:0]  opcode0, opcode1, operand0, operand1;
  fetch_state_t st0, st1;

  logic [7:0] rom0 [4096];
  logic [7:0] rom1 [4096];
  assign rom_data0 = rom0[rom_addr0];
  assign rom_data1 = rom1[rom_addr1];

  nibbler_fetch #(.RESET_PC(12'h000), .LONG_OPS(16'hFF00)) dut0 (
    .clk(clk), .reset_n(reset_n0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .instr_valid(valid0), .instr_ready(ready0), .take_jump(tj0),
    .opcode(opcode0), .operand(operand0), .target(target0), .is_long(long0),
    .instr_pc(instr_pc0), .state_dbg(st0));

  nibbler_fetch #(.RESET_PC(12'hFFF), .LONG_OPS(16'hFF00)) dut1 (
    .clk(clk), .reset_n(reset_n1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .instr_valid(valid1), .instr_ready(ready1), .take_jump(tj1),
    .opcode(opcode1), .operand(operand1), .target(target1), .is_long(long1),
    .instr_pc(instr_pc1), .state_dbg(st1));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset0();
    reset_n0 = 1'b0;
    ready0   = 1'b0;
    tj0      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, valid0}, 0);
    check("rst_addr", {20'd0, rom_addr0}, 32'h000);
    check("rst_opcode", {28'd0, opcode0}, 0);
    check("rst_target", {20'd0, target0}, 0);
    check("rst_is_long", {31'd0, long0}, 0);
    check("rst_instr_pc", {20'd0, instr_pc0}, 32'h000);
    reset_n0 = 1'b1;
  endtask

  // waits for instr_valid; lat = number of falling edges seen up to and including the valid one
  task automatic wait_valid0(output int lat);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (valid0) break;
    end
    if (!valid0) check("valid_timeout", 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        tj;
    logic [3:0]  op;
    logic [3:0]  opr;
    logic [11:0] tgt;
    logic        lng;
    int          lat;
    logic [11:0] nxt;
  } vec_t;

  vec_t vecs[8];

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] long_ops_m;
    logic [11:0] pc_m, pc_n, exp_tgt;
    logic [7:0]  b0, b1;
    logic        lng;
    int          len, gap;
    bit          fresh;

    long_ops_m = 16'hFF00;
    reset_n0 = 1'b0; reset_n1 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; tj0 = 1'b0; tj1 = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      rom0[i] = 8'h00;
      rom1[i] = 8'h00;
    end

    vecs[0] = '{8'h12, 8'h00, 1'b0, 4'h1, 4'h2, 12'h000, 1'b0, 1, 12'h001};
    vecs[1] = '{8'h12, 8'h00, 1'b1, 4'h1, 4'h2, 12'h000, 1'b0, 1, 12'h001};
    vecs[2] = '{8'hC3, 8'h45, 1'b1, 4'hC, 4'h3, 12'h345, 1'b1, 2, 12'h345};
    vecs[3] = '{8'hC3, 8'h45, 1'b0, 4'hC, 4'h3, 12'h345, 1'b1, 2, 12'h002};
    vecs[4] = '{8'h8A, 8'hBC, 1'b1, 4'h8, 4'hA, 12'hABC, 1'b1, 2, 12'hABC};
    vecs[5] = '{8'h7F, 8'hFF, 1'b1, 4'h7, 4'hF, 12'h000, 1'b0, 1, 12'h001};
    vecs[6] = '{8'hC0, 8'h00, 1'b1, 4'hC, 4'h0, 12'h000, 1'b1, 2, 12'h000};
    vecs[7] = '{8'h0E, 8'h55, 1'b1, 4'h0, 4'hE, 12'h000, 1'b0, 1, 12'h001};

    // table: one instruction at address 0, accepted immediately
    for (int v = 0; v < 8; v++) begin
      rom0[0] = vecs[v].b0;
      rom0[1] = vecs[v].b1;
      reset0();
      ready0 = 1'b1;
      tj0    = vecs[v].tj;
      wait_valid0(lat);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_opcode", v), {28'd0, opcode0}, {28'd0, vecs[v].op});
      check($sformatf("v%0d_operand", v), {28'd0, operand0}, {28'd0, vecs[v].opr});
      check($sformatf("v%0d_target", v), {20'd0, target0}, {20'd0, vecs[v].tgt});
      check($sformatf("v%0d_is_long", v), {31'd0, long0}, {31'd0, vecs[v].lng});
      check($sformatf("v%0d_instr_pc", v), {20'd0, instr_pc0}, 32'h000);
      check($sformatf("v%0d_addr_hold", v), {20'd0, rom_addr0}, vecs[v].lng ? 32'h002 : 32'h001);
      @(negedge clk);
      check($sformatf("v%0d_valid_after", v), {31'd0, valid0}, 0);
      check($sformatf("v%0d_next_addr", v), {20'd0, rom_addr0}, {20'd0, vecs[v].nxt});
    end

    // stall in HOLD for 5 cycles, then accept exactly once
    rom0[0] = 8'hC3; rom0[1] = 8'h45; rom0[2] = 8'h12;
    reset0();
    tj0 = 1'b1;
    wait_valid0(lat);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", {31'd0, valid0}, 1);
      check("stall_target", {20'd0, target0}, 32'h345);
      check("stall_opcode", {28'd0, opcode0}, 32'hC);
      check("stall_addr", {20'd0, rom_addr0}, 32'h002);
      if (i < 5) @(negedge clk);
    end
    ready0 = 1'b1; tj0 = 1'b0;
    @(negedge clk);
    ready0 = 1'b0;
    check("stall_accept_valid", {31'd0, valid0}, 0);
    check("stall_accept_addr", {20'd0, rom_addr0}, 32'h002);
    wait_valid0(lat);
    check("stall_next_pc", {20'd0, instr_pc0}, 32'h002);
    check("stall_next_opcode", {28'd0, opcode0}, 32'h1);
    ready0 = 1'b1; tj0 = 1'b1;
    @(negedge clk);
    check("short_jump_ignored", {20'd0, rom_addr0}, 32'h003);

    // reset in F1 discards the half-fetched long op
    rom0[0] = 8'hC3; rom0[1] = 8'h45;
    reset0();
    ready0 = 1'b1;
    @(negedge clk);
    check("f1_addr_before", {20'd0, rom_addr0}, 32'h001);
    reset_n0 = 1'b0;
    #1;
    check("f1_rst_valid", {31'd0, valid0}, 0);
    check("f1_rst_addr", {20'd0, rom_addr0}, 32'h000);
    rom0[0] = 8'h12;
    @(negedge clk);
    reset_n0 = 1'b1;
    wait_valid0(lat);
    check("f1_restart_latency", lat, 1);
    check("f1_restart_opcode", {28'd0, opcode0}, 32'h1);
    check("f1_restart_long", {31'd0, long0}, 0);
    check("f1_restart_target", {20'd0, target0}, 32'h000);

    // wrap: RESET_PC = FFF, long op straddling the top of memory
    rom1[4095] = 8'h9A; rom1[0] = 8'hBC;
    @(negedge clk);
    check("wrap_rst_addr", {20'd0, rom_addr1}, 32'hFFF);
    check("wrap_rst_instr_pc", {20'd0, instr_pc1}, 32'hFFF);
    check("wrap_rst_valid", {31'd0, valid1}, 0);
    reset_n1 = 1'b1;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (valid1) break;
    end
    check("wrap_latency", lat, 2);
    check("wrap_target", {20'd0, target1}, 32'hABC);
    check("wrap_instr_pc", {20'd0, instr_pc1}, 32'hFFF);
    check("wrap_opcode", {28'd0, opcode1}, 32'h9);
    check("wrap_is_long", {31'd0, long1}, 1);
    check("wrap_addr", {20'd0, rom_addr1}, 32'h001);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    check("wrap_accept_valid", {31'd0, valid1}, 0);
    check("wrap_accept_addr", {20'd0, rom_addr1}, 32'h001);

    // random program, random ready/take_jump, checked against an instruction-level model
    for (int i = 0; i < 4096; i++) rom0[i] = 8'($urandom_range(0, 255));
    reset0();
    pc_m  = 12'h000;
    gap   = 1;
    fresh = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (valid0) begin
        pc_n    = pc_m + 12'd1;
        b0      = rom0[pc_m];
        b1      = rom0[pc_n];
        lng     = long_ops_m[b0[7:4]];
        len     = lng ? 2 : 1;
        exp_tgt = lng ? {b0[3:0], b1} : 12'h000;
        exp_q.push_back({20'd0, exp_tgt});
        if (fresh) check("rnd_latency", gap, len);
        fresh = 1'b0;
        check("rnd_opcode", {28'd0, opcode0}, {28'd0, b0[7:4]});
        check("rnd_operand", {28'd0, operand0}, {28'd0, b0[3:0]});
        check("rnd_target", {20'd0, target0}, exp_q.pop_front());
        check("rnd_is_long", {31'd0, long0}, {31'd0, lng});
        check("rnd_instr_pc", {20'd0, instr_pc0}, {20'd0, pc_m});
        check("rnd_addr", {20'd0, rom_addr0}, {20'd0, pc_m + 12'(len)});
        ready0 = ($urandom_range(0, 3) != 0);
        tj0    = 1'($urandom_range(0, 1));
        if (ready0) begin
          pc_m  = (tj0 && lng) ? exp_tgt : pc_m + 12'(len);
          fresh = 1'b1;
          gap   = 0;
        end
      end else begin
        gap++;
        ready0 = 1'($urandom_range(0, 1));
        tj0    = 1'($urandom_range(0, 1));
        if (gap > 4) begin
          check("rnd_timeout", 0, 1);
          break;
        end
      end
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
